// File: rtl/neureka_wmem_responder_pkg.sv
// Shared types and constants for the weight-memory TCDM responder.
package neureka_wmem_responder_pkg;

  localparam int unsigned NEUREKA_WMEM_NB_WORDS = 512;
  localparam int unsigned WMEM_RSP_DEPTH        = 2;
  localparam int unsigned WMEM_OCC_W            = $clog2(WMEM_RSP_DEPTH + 1);

  typedef struct packed {
    logic                  busy;
    logic                  err_sticky;
    logic [WMEM_OCC_W-1:0] occupancy;
  } wmem_responder_flags_t;

endpackage

// File: rtl/neureka_wmem_responder_if.sv
// HCI-core style TCDM request/response bundle between an initiator and the weight memory.
interface neureka_wmem_responder_if #(
  parameter int unsigned DW = 256,
  parameter int unsigned AW = 32,
  parameter int unsigned IW = 8
);

  logic            req;
  logic            gnt;
  logic [AW-1:0]   add;
  logic            wen;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   data;
  logic [IW-1:0]   id;
  logic            r_valid;
  logic            r_ready;
  logic [DW-1:0]   r_data;
  logic [IW-1:0]   r_id;
  logic            r_err;

  modport master (
    output req, add, wen, be, data, id, r_ready,
    input  gnt, r_valid, r_data, r_id, r_err
  );

  modport slave (
    input  req, add, wen, be, data, id, r_ready,
    output gnt, r_valid, r_data, r_id, r_err
  );

endinterface

// File: rtl/neureka_wmem_responder_rsp_fifo.sv
// Fall-through response FIFO: a push into an empty FIFO is visible on the output the same cycle.
module neureka_wmem_responder_rsp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic                       valid,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]    occ_q;
  logic             empty, do_write, do_read;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (occ_q == '0);
  assign valid    = ~empty | push;
  assign rdata    = empty ? wdata : store_q[rd_ptr_q];
  // An entry pushed into an empty FIFO and popped in the same cycle is never stored.
  assign do_write = push & ~(empty & pop);
  assign do_read  = pop & ~empty;
  assign occ      = occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_write) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_read)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      occ_q <= occ_q + OW'(do_write) - OW'(do_read);
    end
  end

  always_ff @(posedge clk) begin
    if (do_write && !clear) store_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/neureka_wmem_responder.sv
// TCDM target serving single-beat reads/writes from a word-addressed weight memory,
// returning in-order responses through a one-entry in-flight stage and a fall-through FIFO.
module neureka_wmem_responder
  import neureka_wmem_responder_pkg::*;
#(
  parameter int unsigned DW        = 256,
  parameter int unsigned AW        = 32,
  parameter int unsigned IW        = 8,
  parameter int unsigned NB_WORDS  = NEUREKA_WMEM_NB_WORDS,
  parameter int unsigned RSP_DEPTH = WMEM_RSP_DEPTH,
  parameter bit          WRITE_RSP = 1'b1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           enable_i,
  neureka_wmem_responder_if.slave        tcdm,
  output wmem_responder_flags_t          flags_o
);

  localparam int unsigned OFFS  = $clog2(DW / 8);
  localparam int unsigned IDX_W = AW - OFFS;
  localparam int unsigned MW    = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
  localparam int unsigned OW    = $clog2(RSP_DEPTH + 1);
  localparam int unsigned CW    = OW + 1;
  localparam int unsigned EW    = DW + 1 + IW;

  logic [DW-1:0]    mem_q [NB_WORDS];
  logic [IDX_W-1:0] idx;
  logic [MW-1:0]    mem_idx;
  logic             in_range, needs_rsp, pop, credit_ok;
  logic [DW-1:0]    rd_data;
  logic             infl_valid_q;
  logic [EW-1:0]    infl_q;
  logic [EW-1:0]    fifo_rdata;
  logic             fifo_valid;
  logic [OW-1:0]    occ;
  logic             err_sticky_q;
  logic             unused_add;

  assign idx        = tcdm.add[AW-1:OFFS];
  assign unused_add = ^tcdm.add[OFFS-1:0];
  assign in_range   = idx < IDX_W'(NB_WORDS);
  assign mem_idx    = idx[MW-1:0];
  assign needs_rsp  = tcdm.wen | WRITE_RSP;
  assign rd_data    = (tcdm.wen && in_range) ? mem_q[mem_idx] : '0;

  // A pop this cycle frees a slot the new grant may claim immediately.
  assign pop        = fifo_valid & tcdm.r_ready;
  assign credit_ok  = (CW'(occ) + CW'(infl_valid_q)) < (CW'(RSP_DEPTH) + CW'(pop));
  assign tcdm.gnt   = tcdm.req & enable_i & ~clear_i & credit_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      infl_valid_q <= 1'b0;
      infl_q       <= '0;
      err_sticky_q <= 1'b0;
    end else if (clear_i) begin
      infl_valid_q <= 1'b0;
      infl_q       <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      infl_valid_q <= tcdm.gnt & needs_rsp;
      if (tcdm.gnt) begin
        infl_q <= {rd_data, ~in_range, tcdm.id};
        if (!in_range) err_sticky_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (tcdm.gnt && !tcdm.wen && in_range) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (tcdm.be[b]) mem_q[mem_idx][8*b +: 8] <= tcdm.data[8*b +: 8];
      end
    end
  end

  neureka_wmem_responder_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (EW)
  ) u_rsp_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clear (clear_i),
    .push  (infl_valid_q),
    .wdata (infl_q),
    .pop   (pop),
    .valid (fifo_valid),
    .rdata (fifo_rdata),
    .occ   (occ)
  );

  assign tcdm.r_valid = fifo_valid;
  assign tcdm.r_data  = fifo_rdata[EW-1 -: DW];
  assign tcdm.r_err   = fifo_rdata[IW];
  assign tcdm.r_id    = fifo_rdata[IW-1:0];

  assign flags_o.busy       = (occ != '0) | infl_valid_q;
  assign flags_o.err_sticky = err_sticky_q;
  assign flags_o.occupancy  = WMEM_OCC_W'(occ);

endmodule

// File: tb/tb_neureka_wmem_responder.sv
// Randomised and directed bench for the weight-memory responder against a queue-based model.
module tb_neureka_wmem_responder;
  import neureka_wmem_responder_pkg::*;

  localparam int unsigned DW = 256;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 8;
  localparam int unsigned NB = 512;
  localparam int unsigned RD = 2;
  localparam int unsigned BW = DW / 8;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, enable = 1'b0;
  wmem_responder_flags_t flags;

  neureka_wmem_responder_if #(.DW(DW), .AW(AW), .IW(IW)) tcdm ();

  neureka_wmem_responder #(
    .DW(DW), .AW(AW), .IW(IW), .NB_WORDS(NB), .RSP_DEPTH(RD), .WRITE_RSP(1'b1)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clear_i  (clear),
    .enable_i (enable),
    .tcdm     (tcdm),
    .flags_o  (flags)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string nm, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Model: a response queue in grant order plus a byte-accurate memory image.
  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic          err;
    bit            dk;
  } rsp_t;

  rsp_t          q[$];
  logic [DW-1:0] mdl_mem [NB];
  bit            known [NB];
  bit            mdl_sticky = 0;
  bit            mdl_newest = 0;

  always @(negedge clk) begin : model
    logic [AW-6:0] w;
    bit            inr, exp_gnt, exp_pop, full;
    rsp_t          e;
    if (!rst_n) begin
      q.delete();
      mdl_sticky = 0;
      mdl_newest = 0;
      for (int i = 0; i < NB; i++) known[i] = 0;
    end else begin
      w       = tcdm.add[AW-1:5];
      inr     = (w < NB);
      exp_pop = (q.size() != 0) && tcdm.r_ready;
      exp_gnt = tcdm.req && enable && !clear && (q.size() < RD + int'(exp_pop));
      check("gnt", tcdm.gnt, exp_gnt);
      check("r_valid", tcdm.r_valid, q.size() != 0);
      if (q.size() != 0) begin
        check("r_id", tcdm.r_id, q[0].id);
        check("r_err", tcdm.r_err, q[0].err);
        if (q[0].dk) check("r_data", tcdm.r_data, q[0].data);
      end
      check("busy", flags.busy, q.size() != 0);
      check("err_sticky", flags.err_sticky, mdl_sticky);
      check("occupancy", flags.occupancy, q.size() - int'(mdl_newest));
      if (clear) begin
        q.delete();
        mdl_sticky = 0;
        mdl_newest = 0;
      end else begin
        if (exp_pop) void'(q.pop_front());
        mdl_newest = 0;
        if (exp_gnt) begin
          e.id  = tcdm.id;
          e.err = !inr;
          e.dk  = 1;
          e.data = '0;
          if (!inr) mdl_sticky = 1;
          if (tcdm.wen) begin
            if (inr) begin
              e.data = mdl_mem[w[8:0]];
              e.dk   = known[w[8:0]];
            end
          end else if (inr) begin
            full = 1;
            for (int b = 0; b < BW; b++) begin
              if (tcdm.be[b]) mdl_mem[w[8:0]][8*b +: 8] = tcdm.data[8*b +: 8];
              else full = 0;
            end
            if (full) known[w[8:0]] = 1;
          end
          q.push_back(e);
          mdl_newest = 1;
        end
      end
    end
  end

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tcdm.req  = 1'b0;
    tcdm.wen  = 1'b1;
    tcdm.add  = '0;
    tcdm.be   = '0;
    tcdm.data = '0;
    tcdm.id   = '0;
  endtask

  task automatic put(input bit wen, input logic [AW-6:0] w, input logic [BW-1:0] be,
                     input logic [DW-1:0] d, input logic [IW-1:0] id);
    logic [4:0] lo;
    lo        = 5'($urandom_range(0, 31));
    tcdm.req  = 1'b1;
    tcdm.wen  = wen;
    tcdm.add  = {w, lo};
    tcdm.be   = be;
    tcdm.data = d;
    tcdm.id   = id;
  endtask

  // Single request; returns one cycle after its grant edge with req dropped.
  task automatic txn(input string nm, input bit wen, input logic [AW-6:0] w,
                     input logic [BW-1:0] be, input logic [DW-1:0] d, input logic [IW-1:0] id);
    int k = 0;
    put(wen, w, be, d, id);
    @(negedge clk);
    while (!tcdm.gnt && k < 50) begin
      step();
      @(negedge clk);
      k++;
    end
    check({nm, "_gnt_latency"}, k, 0);
    step();
    idle();
  endtask

  task automatic expect_rsp(input string nm, input logic [IW-1:0] id, input logic [DW-1:0] d,
                            input bit err);
    int k = 0;
    @(negedge clk);
    while (!tcdm.r_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_rsp_latency"}, k, 0);
    check({nm, "_rsp_id"}, tcdm.r_id, id);
    check({nm, "_rsp_data"}, tcdm.r_data, d);
    check({nm, "_rsp_err"}, tcdm.r_err, err);
    step();
  endtask

  // Issue n reads to words base.. with ids 0.. under current r_ready for a fixed cycle count.
  task automatic burst(input int n, input int unsigned base, input int cycles, output int granted);
    int k = 0;
    for (int c = 0; c < cycles; c++) begin
      if (k < n) put(1'b1, (AW-5)'(base + k), '0, '0, IW'(k));
      else idle();
      @(negedge clk);
      if (tcdm.gnt) k++;
      step();
    end
    granted = k;
  endtask

  logic [DW-1:0] pat, exp_d, snap_d;
  logic [IW-1:0] snap_id;
  logic [IW-1:0] got[$];
  int            k, gcnt, vcnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    idle();
    tcdm.r_ready = 1'b0;
    #3;
    check("reset_r_valid", tcdm.r_valid, 0);
    check("reset_r_data", tcdm.r_data, 0);
    check("reset_r_id", tcdm.r_id, 0);
    check("reset_gnt", tcdm.gnt, 0);
    check("reset_flags", flags, 0);
    step();
    step();
    rst_n = 1'b1;
    enable = 1'b1;
    tcdm.r_ready = 1'b1;

    // Fill memory so every later read has a defined expectation.
    k = 0;
    for (int c = 0; c < 2000 && k < NB; c++) begin
      put(1'b0, (AW-5)'(k), '1, rand_word(), IW'(k));
      @(negedge clk);
      if (tcdm.gnt) k++;
      step();
    end
    check("init_count", k, NB);
    idle();
    repeat (3) step();

    // Write pattern, then read it back.
    pat = {32{8'hA5}};
    txn("wr3", 1'b0, 3, '1, pat, 8'h11);
    expect_rsp("wr3", 8'h11, '0, 1'b0);
    txn("rd3", 1'b1, 3, '0, '0, 8'h22);
    expect_rsp("rd3", 8'h22, pat, 1'b0);

    // Partial write only touches the low four bytes.
    txn("wr5a", 1'b0, 5, '1, '1, 8'h30);
    expect_rsp("wr5a", 8'h30, '0, 1'b0);
    txn("wr5b", 1'b0, 5, BW'(32'h0000_000F), '0, 8'h31);
    expect_rsp("wr5b", 8'h31, '0, 1'b0);
    exp_d = '1;
    exp_d[31:0] = '0;
    txn("rd5", 1'b1, 5, '0, '0, 8'h32);
    expect_rsp("rd5", 8'h32, exp_d, 1'b0);

    // Stalled responder: two credits only, then ordered drain.
    tcdm.r_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      if (k < 4) put(1'b1, (AW-5)'(10 + k), '0, '0, IW'(k));
      @(negedge clk);
      if (tcdm.gnt) k++;
      if (c == 3) begin
        snap_d  = tcdm.r_data;
        snap_id = tcdm.r_id;
      end
      if (c > 3) begin
        check("stall_valid", tcdm.r_valid, 1);
        check("stall_id_stable", tcdm.r_id, snap_id);
        check("stall_data_stable", tcdm.r_data, snap_d);
      end
      step();
    end
    check("stall_grants", k, 2);
    check("stall_head_id", snap_id, 0);
    check("stall_head_data", snap_d, mdl_mem[10]);
    tcdm.r_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 30 && got.size() < 4; c++) begin
      if (k < 4) put(1'b1, (AW-5)'(10 + k), '0, '0, IW'(k));
      else idle();
      @(negedge clk);
      if (c == 0) check("gnt_resume_on_pop", tcdm.gnt, 1);
      if (tcdm.gnt) k++;
      if (tcdm.r_valid) got.push_back(tcdm.r_id);
      step();
    end
    idle();
    check("drain_count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) check("drain_order", got[i], IW'(i));
    end
    repeat (2) step();

    // Sustained throughput with r_ready held high.
    gcnt = 0;
    vcnt = 0;
    for (int c = 0; c < 17; c++) begin
      if (c < 16) put(1'b1, (AW-5)'(20 + c), '0, '0, IW'(8'h40 + c));
      else idle();
      @(negedge clk);
      if (c < 16 && tcdm.gnt) gcnt++;
      if (c >= 1 && tcdm.r_valid) vcnt++;
      step();
    end
    check("stream_grants", gcnt, 16);
    check("stream_rsps", vcnt, 16);
    repeat (2) step();

    // Out-of-range read, then an in-range one.
    txn("oob", 1'b1, (AW-5)'(NB), '0, '0, 8'h50);
    check("oob_sticky", flags.err_sticky, 1);
    expect_rsp("oob", 8'h50, '0, 1'b1);
    txn("after_oob", 1'b1, 3, '0, '0, 8'h51);
    expect_rsp("after_oob", 8'h51, pat, 1'b0);

    // Clear with two queued responses.
    tcdm.r_ready = 1'b0;
    burst(2, 3, 4, k);
    check("clr_grants", k, 2);
    @(negedge clk);
    check("clr_occ_before", flags.occupancy, 2);
    step();
    clear = 1'b1;
    put(1'b1, 3, '0, '0, 8'h77);
    @(negedge clk);
    check("clr_gnt_forced_low", tcdm.gnt, 0);
    step();
    clear = 1'b0;
    idle();
    @(negedge clk);
    check("clr_r_valid", tcdm.r_valid, 0);
    check("clr_occ", flags.occupancy, 0);
    check("clr_sticky", flags.err_sticky, 0);
    step();
    tcdm.r_ready = 1'b1;
    txn("clr_reread", 1'b1, 3, '0, '0, 8'h61);
    expect_rsp("clr_reread", 8'h61, pat, 1'b0);

    // Random traffic; the model process checks every cycle.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 75) begin
        put($urandom_range(0, 1) == 1,
            ($urandom_range(0, 9) == 0) ? (AW-5)'($urandom_range(NB, NB + 20))
                                        : (AW-5)'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 1) ? '1 : BW'($urandom()),
            rand_word(), IW'($urandom()));
      end else idle();
      tcdm.r_ready = $urandom_range(0, 99) < 70;
      enable       = $urandom_range(0, 99) < 90;
      clear        = $urandom_range(0, 99) < 3;
      step();
    end
    idle();
    clear = 1'b0;
    enable = 1'b1;
    tcdm.r_ready = 1'b1;
    repeat (5) step();

    // Asynchronous reset with responses pending.
    tcdm.r_ready = 1'b0;
    burst(2, 7, 4, k);
    check("rst_grants", k, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_r_valid", tcdm.r_valid, 0);
    check("rst_async_r_data", tcdm.r_data, 0);
    check("rst_async_r_id", tcdm.r_id, 0);
    check("rst_async_r_err", tcdm.r_err, 0);
    check("rst_async_flags", flags, 0);
    step();
    step();
    rst_n = 1'b1;
    tcdm.r_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_no_stale", tcdm.r_valid, 0);
      step();
    end
    txn("post_rst_wr", 1'b0, 9, '1, pat, 8'h70);
    expect_rsp("post_rst_wr", 8'h70, '0, 1'b0);
    txn("post_rst_rd", 1'b1, 9, '0, '0, 8'h71);
    expect_rsp("post_rst_rd", 8'h71, pat, 1'b0);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neureka_wmem_responder.md
Name: neureka_wmem_responder

Overview:
- TCDM target that terminates an HCI-core initiator port, such as the streamer's dedicated weight-memory port.
- Serves single-beat read/write requests from an internal word-addressed weight memory.
- Returns responses in order, with id echo and r_ready backpressure.
- Sits inside the weight-memory subsystem; the streamer's r_valid/id filters sit on the initiator side.

Parameters:
- DW, 256, data width in bits (matches NEUREKA_MEM_BANDWIDTH_EXT class widths; multiple of 8)
- AW, 32, byte address width
- IW, 8, request/response id width
- NB_WORDS, 512, memory depth in DW-bit words
- RSP_DEPTH, 2, response FIFO depth (≥2)
- WRITE_RSP, 1, 1 = writes also produce a response beat

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous flush of in-flight/queued responses
- enable_i  in  1  0 = never grant
- tcdm_req_i  in  1  request valid
- tcdm_gnt_o  out  1  request accepted this cycle
- tcdm_add_i  in  AW  byte address
- tcdm_wen_i  in  1  1 = read, 0 = write
- tcdm_be_i  in  DW/8  byte enables (writes)
- tcdm_data_i  in  DW  write data
- tcdm_id_i  in  IW  transaction id
- tcdm_r_valid_o  out  1  response valid
- tcdm_r_ready_i  in  1  response accepted
- tcdm_r_data_o  out  DW  read data
- tcdm_r_id_o  out  IW  echoed id
- tcdm_r_err_o  out  1  response to out-of-range access
- flags_o  out  struct  {busy, err_sticky, occupancy}

Behaviour:
- Reset: every output is 0, the FIFO is empty, the in-flight stage is empty, and err_sticky = 0. Memory contents are undefined.
- Word index = tcdm_add_i[AW-1:log2(DW/8)]. Low address bits are ignored.
- Out-of-range access (index ≥ NB_WORDS):
  - write is dropped;
  - read returns data 0;
  - r_err = 1 on that response;
  - err_sticky is set and held until clear_i or reset.
- Credit check:
  - avail = RSP_DEPTH − occ − inflight + (r_valid & r_ready).
  - gnt = req & enable & (avail > 0), combinational from req.
  - gnt never asserts without req.
- Accepted read:
  - Memory is read at the grant edge T.
  - The in-flight stage holds {data, id, err} at T+1.
  - The FIFO is fall-through, so r_valid asserts at T+1.
  - Minimum latency is 1 cycle.
- Accepted write:
  - Bytes with be = 1 are updated at edge T.
  - If WRITE_RSP = 1, a response is queued like a read, with r_data = 0.
  - If WRITE_RSP = 0, no response and no credit is consumed.
- Ordering: responses leave in grant order. Ids are echoed unchanged.
- Throughput: 1 request/cycle sustained while r_ready = 1 and RSP_DEPTH ≥ 2.
- Backpressure:
  - r_valid/r_data/r_id/r_err stay stable while r_valid & !r_ready.
  - gnt drops once avail = 0.
  - gnt resumes in the same cycle as the pop that frees a credit.
- Read-after-write to the same word in consecutive grants returns the new data (write at edge T is visible to a read granted at T+1).
- Simultaneous push and pop on a full FIFO is allowed only via the pop credit; occupancy is unchanged.
- clear_i, in the cycle it is high:
  - gnt forced 0;
  - FIFO and in-flight stage flushed;
  - err_sticky cleared;
  - memory retained;
  - r_valid = 0 the next cycle.
- enable_i = 0:
  - no new grants;
  - queued responses still drain;
  - busy = (occ + inflight ≠ 0).
- Asynchronous reset mid-transaction discards all pending responses. Outputs return to reset values immediately.

Decomposition:
- neureka_package:
  - wmem_responder_flags_t {busy, err_sticky, occupancy[$clog2(RSP_DEPTH+1)-1:0]};
  - constant NEUREKA_WMEM_NB_WORDS.
- Sub-module neureka_rsp_fifo:
  - fall-through FIFO of {data, err, id};
  - push/pop/occupancy/clear;
  - parameter DEPTH.
- The top handles address decode, memory array, credit logic and the in-flight stage.

Test Plan:
- Write 0xA5-pattern to word 3 with be all ones, id 0x11, then read word 3 with id 0x22 (r_ready = 1) → read gnt same cycle as req; r_valid one cycle after gnt; r_data = pattern; r_id = 0x22; write response r_id = 0x11, r_data = 0.
- Partial write: be = 0x0000_000F over 0xFFFF…, then read → only the low 4 bytes change.
- r_ready held 0, 4 back-to-back reads (RSP_DEPTH = 2) → 2 grants then gnt = 0; on releasing r_ready, responses arrive in id order 0, 1, 2, 3 with stable data while stalled.
- 16 back-to-back reads with r_ready = 1 → gnt high every cycle; 16 responses in 16 consecutive cycles.
- Read index NB_WORDS (add = 512 × 32) → r_err = 1, r_data = 0, err_sticky = 1; a following in-range access gives r_err = 0.
- 2 responses queued, then clear_i pulse → r_valid = 0 next cycle, occupancy = 0, err_sticky = 0, memory data preserved on re-read.
- rst_ni low while responses are queued → all outputs 0 asynchronously; no stale response after release.
